// File: rtl/phase_scheduler.sv
// Round-robin green/yellow/all-red phase scheduler for a four-approach intersection.
// Optional emergency preemption (ev_req/ev_dir) is built when EMERGENCY_PREEMPT_EN is defined.
module phase_scheduler #(
   parameter int GREEN_MIN = 10,
   parameter int GREEN_MAX = 30,
   parameter int YELLOW_T  = 4,
   parameter int ALLRED_T  = 2,
   parameter int CW        = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] req,
`ifdef EMERGENCY_PREEMPT_EN
   input  logic       ev_req,
   input  logic [1:0] ev_dir,
`endif
   output logic [3:0] grant,
   output logic [3:0] yellow,
   output logic [3:0] red,
   output logic [1:0] phase,
   output logic       chg
);

   typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW} state_e;

   localparam logic [CW:0]   GMIN_C  = (CW+1)'(GREEN_MIN);
   localparam logic [CW:0]   GMAX_C  = (CW+1)'(GREEN_MAX);
   localparam logic [CW-1:0] YLAST_C = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] ALAST_C = CW'(ALLRED_T - 1);

   state_e        state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic [CW-1:0] timer_q, timer_d;
   logic [3:0]    pending_q, pending_d;
   logic [3:0]    grant_q, grant_d;
   logic [3:0]    yellow_q, yellow_d;
   logic [3:0]    red_q, red_d;
   logic          chg_q, chg_d;

   logic          ev_act;
   logic [1:0]    ev_tgt;
   logic [3:0]    own_mask;
   logic          other;
   logic [CW:0]   tmr_nxt;
   logic          go;

`ifdef EMERGENCY_PREEMPT_EN
   assign ev_act = ev_req;
   assign ev_tgt = ev_dir;
`else
   assign ev_act = 1'b0;
   assign ev_tgt = 2'd0;
`endif

   // First pending approach after cur, wrapping; cur itself is checked last.
   function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] cur);
      logic [1:0] idx;
      logic       found;
      rr_pick = cur;
      found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = cur + 2'(k);
         if (!found && pend[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   assign own_mask = (state_q == S_GREEN) ? (4'b0001 << phase_q) : 4'b0000;
   assign other    = |(pending_q & ~(4'b0001 << phase_q));
   assign tmr_nxt  = {1'b0, timer_q} + 1'b1;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      timer_d   = timer_q;
      pending_d = pending_q | (req & ~own_mask);
      go        = 1'b0;

      case (state_q)
         S_ALLRED: begin
            if (tick && timer_q == ALAST_C) begin
               state_d = S_GREEN;
               phase_d = ev_act ? ev_tgt : rr_pick(pending_q, phase_q);
               go      = 1'b1;
            end
         end
         S_GREEN: begin
            if (ev_act) begin
               // Preempt: leave immediately unless already serving the target.
               if (tick && phase_q != ev_tgt) begin
                  state_d = S_YELLOW;
                  go      = 1'b1;
               end
            end else if (tick && other && tmr_nxt >= GMIN_C &&
                         (!req[phase_q] || tmr_nxt >= GMAX_C)) begin
               state_d = S_YELLOW;
               go      = 1'b1;
            end
         end
         S_YELLOW: begin
            if (tick && timer_q == YLAST_C) begin
               state_d = S_ALLRED;
               go      = 1'b1;
            end
         end
         default: begin
            state_d = S_ALLRED;
            go      = 1'b1;
         end
      endcase

      if (go) begin
         timer_d = '0;
      end else if (tick && timer_q != '1) begin
         timer_d = timer_q + 1'b1;
      end

      if (go && state_d == S_GREEN) begin
         pending_d[phase_d] = 1'b0;
      end

      grant_d  = (state_d == S_GREEN)  ? (4'b0001 << phase_d) : 4'b0000;
      yellow_d = (state_d == S_YELLOW) ? (4'b0001 << phase_d) : 4'b0000;
      red_d    = ~(grant_d | yellow_d);
      chg_d    = go;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_ALLRED;
         phase_q   <= 2'd0;
         timer_q   <= '0;
         pending_q <= 4'b0000;
         grant_q   <= 4'b0000;
         yellow_q  <= 4'b0000;
         red_q     <= 4'b1111;
         chg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
         grant_q   <= grant_d;
         yellow_q  <= yellow_d;
         red_q     <= red_d;
         chg_q     <= chg_d;
      end
   end

   assign grant  = grant_q;
   assign yellow = yellow_q;
   assign red    = red_q;
   assign phase  = phase_q;
   assign chg    = chg_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1, tick every cycle.
// The preemption scenario is included when EMERGENCY_PREEMPT_EN is defined.
module tb_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b1;
   logic [3:0] req = 4'b0000;
`ifdef EMERGENCY_PREEMPT_EN
   logic       ev_req = 1'b0;
   logic [1:0] ev_dir = 2'd0;
`endif
   logic [3:0] grant, yellow, red;
   logic [1:0] phase;
   logic       chg;

   int n_chk  = 0;
   int n_fail = 0;

   phase_scheduler #(
      .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1), .CW(6)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .req(req),
`ifdef EMERGENCY_PREEMPT_EN
      .ev_req(ev_req), .ev_dir(ev_dir),
`endif
      .grant(grant), .yellow(yellow), .red(red), .phase(phase), .chg(chg)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in ALLRED just after reset release; the next edge enters green 0.
   task automatic do_reset();
      rst = 1'b0;
      req = 4'b0000;
`ifdef EMERGENCY_PREEMPT_EN
      ev_req = 1'b0;
      ev_dir = 2'd0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b0;
      req = 4'b0000;
      step();
      n_chk++;
      if ({grant, yellow, red, phase, chg} !== {4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got g=%b y=%b r=%b ph=%0d chg=%b, expected g=0000 y=0000 r=1111 ph=0 chg=0",
                  grant, yellow, red, phase, chg);
      end
      rst = 1'b1;
      n_chk++;
      if (red !== 4'b1111) begin
         n_fail++;
         $display("FAIL release_red: got %b expected 1111", red);
      end
      step();
      n_chk++;
      if ({grant, red, chg} !== {4'b0001, 4'b1110, 1'b1}) begin
         n_fail++;
         $display("FAIL first_green: got g=%b r=%b chg=%b, expected g=0001 r=1110 chg=1", grant, red, chg);
      end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (grant !== 4'b0001 || chg !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rest_in_green: %0d bad cycles, expected 0 (last g=%b chg=%b)", bad, grant, chg);
      end
   endtask

   task automatic test_gap_out();
      do_reset();
      step();
      req = 4'b0100;
      step();
      req = 4'b0000;
      step();
      n_chk++;
      if (grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL gap_green0: got %b expected 0001", grant);
      end
      step();
      n_chk++;
      if ({grant, yellow, chg} !== {4'b0000, 4'b0001, 1'b1}) begin
         n_fail++;
         $display("FAIL gap_yellow_start: got g=%b y=%b chg=%b, expected g=0000 y=0001 chg=1", grant, yellow, chg);
      end
      step();
      n_chk++;
      if ({yellow, chg} !== {4'b0001, 1'b0}) begin
         n_fail++;
         $display("FAIL gap_yellow_hold: got y=%b chg=%b, expected y=0001 chg=0", yellow, chg);
      end
      step();
      n_chk++;
      if ({grant, yellow, red, chg} !== {4'b0000, 4'b0000, 4'b1111, 1'b1}) begin
         n_fail++;
         $display("FAIL gap_allred: got g=%b y=%b r=%b chg=%b, expected 0000 0000 1111 1", grant, yellow, red, chg);
      end
      step();
      n_chk++;
      if ({grant, red, phase, chg} !== {4'b0100, 4'b1011, 2'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL gap_green2: got g=%b r=%b ph=%0d chg=%b, expected 0100 1011 2 1", grant, red, phase, chg);
      end
      repeat (5) step();
      n_chk++;
      if (grant !== 4'b0100) begin
         n_fail++;
         $display("FAIL gap_green2_hold: got %b expected 0100", grant);
      end
   endtask

   task automatic test_max_extend();
      int short_g;
      do_reset();
      step();
      req = 4'b0011;
      step();
      req = 4'b0001;
      short_g = 0;
      // Green entered at E0; edges E1..E5 must still show green 0.
      if (grant !== 4'b0001) short_g++;
      for (int i = 2; i <= 5; i++) begin
         step();
         if (grant !== 4'b0001) short_g++;
      end
      n_chk++;
      if (short_g != 0) begin
         n_fail++;
         $display("FAIL max_green_len: %0d early-exit cycles, expected 0", short_g);
      end
      step();
      n_chk++;
      if ({grant, yellow} !== {4'b0000, 4'b0001}) begin
         n_fail++;
         $display("FAIL max_yellow: got g=%b y=%b, expected 0000 0001", grant, yellow);
      end
      step();
      step();
      n_chk++;
      if (red !== 4'b1111) begin
         n_fail++;
         $display("FAIL max_allred: got %b expected 1111", red);
      end
      step();
      n_chk++;
      if ({grant, phase} !== {4'b0010, 2'd1}) begin
         n_fail++;
         $display("FAIL max_green1: got g=%b ph=%0d, expected 0010 1", grant, phase);
      end
      req = 4'b0000;
   endtask

   task automatic test_round_robin();
      int seen0;
      logic [3:0] g12, g18;
      do_reset();
      step();
      req = 4'b0100;
      step();
      req = 4'b0000;
      repeat (5) step();
      n_chk++;
      if (grant !== 4'b0100) begin
         n_fail++;
         $display("FAIL rr_green2: got %b expected 0100", grant);
      end
      req = 4'b1010;
      step();
      req = 4'b0000;
      seen0 = 0;
      g12 = 4'b0000;
      g18 = 4'b0000;
      for (int e = 8; e <= 24; e++) begin
         step();
         if (grant[0] === 1'b1) seen0++;
         if (e == 12) g12 = grant;
         if (e == 18) g18 = grant;
      end
      n_chk++;
      if (g12 !== 4'b1000) begin
         n_fail++;
         $display("FAIL rr_first_is_3: got %b expected 1000", g12);
      end
      n_chk++;
      if (g18 !== 4'b0010) begin
         n_fail++;
         $display("FAIL rr_second_is_1: got %b expected 0010", g18);
      end
      n_chk++;
      if (seen0 != 0 || grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL rr_skip_0: green0 cycles=%0d final g=%b, expected 0 and 0010", seen0, grant);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step();
      req = 4'b0100;
      step();
      req = 4'b0000;
      step();
      step();
      n_chk++;
      if (yellow !== 4'b0001) begin
         n_fail++;
         $display("FAIL ar_in_yellow: got %b expected 0001", yellow);
      end
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if ({grant, yellow, red, chg} !== {4'b0000, 4'b0000, 4'b1111, 1'b0}) begin
         n_fail++;
         $display("FAIL ar_immediate: got g=%b y=%b r=%b chg=%b, expected 0000 0000 1111 0", grant, yellow, red, chg);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      n_chk++;
      if ({phase, red} !== {2'd0, 4'b1111}) begin
         n_fail++;
         $display("FAIL ar_release: got ph=%0d r=%b, expected 0 1111", phase, red);
      end
      step();
      n_chk++;
      if ({grant, phase} !== {4'b0001, 2'd0}) begin
         n_fail++;
         $display("FAIL ar_green0: got g=%b ph=%0d, expected 0001 0", grant, phase);
      end
      // A surviving pending[2] would force a gap-out within these cycles.
      repeat (6) step();
      n_chk++;
      if (grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL ar_pending_cleared: got %b expected 0001", grant);
      end
   endtask

`ifdef EMERGENCY_PREEMPT_EN
   task automatic test_emergency();
      int lost;
      do_reset();
      step();
      ev_req = 1'b1;
      ev_dir = 2'd3;
      req    = 4'b0111;
      step();
      n_chk++;
      if ({grant, yellow} !== {4'b0000, 4'b0001}) begin
         n_fail++;
         $display("FAIL ev_yellow: got g=%b y=%b, expected 0000 0001", grant, yellow);
      end
      step();
      n_chk++;
      if (yellow !== 4'b0001) begin
         n_fail++;
         $display("FAIL ev_yellow_len: got %b expected 0001", yellow);
      end
      step();
      n_chk++;
      if (red !== 4'b1111) begin
         n_fail++;
         $display("FAIL ev_allred: got %b expected 1111", red);
      end
      step();
      n_chk++;
      if ({grant, phase} !== {4'b1000, 2'd3}) begin
         n_fail++;
         $display("FAIL ev_green3: got g=%b ph=%0d, expected 1000 3", grant, phase);
      end
      lost = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (grant !== 4'b1000) lost++;
      end
      n_chk++;
      if (lost != 0) begin
         n_fail++;
         $display("FAIL ev_hold: %0d cycles off green 3, expected 0", lost);
      end
      ev_req = 1'b0;
      req    = 4'b0000;
   endtask
`endif

   initial begin
      test_reset();
      test_gap_out();
      test_max_extend();
      test_round_robin();
      test_async_reset();
`ifdef EMERGENCY_PREEMPT_EN
      test_emergency();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
